// File: rtl/sub_word_arbiter_pkg.sv
// Shared types for the SubWord arbiter: byte/word views, FSM states and
// the LANES legality helpers used at elaboration.
package sub_word_arbiter_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  // Counter must index 4/LANES substitution steps, never narrower than one bit.
  function automatic int cnt_width(input int lanes);
    return (lanes == 1) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, one byte in, one byte out, purely combinational.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_ofs;

  assign bit_ofs  = {in_byte, 3'b000};
  assign out_byte = SBOX_TBL[11'd2047 - bit_ofs -: 8];

endmodule

// File: rtl/sub_word_rr_grant.sv
// Two-input round-robin grant: a lone valid always wins, a tie goes to rr_ptr.
module sub_word_rr_grant (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sub_word_arbiter.sv
// Shares a LANES-wide S-box engine between key expansion (req 0) and the
// cipher column path (req 1); each word takes 4/LANES cycles of substitution.
module sub_word_arbiter
  import sub_word_arbiter_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_word0,
  input  logic [31:0] req_word1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_word,
  output logic        busy
);

  localparam int STEPS = 4 / LANES;
  localparam int CNT_W = cnt_width(LANES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  generate
    if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("sub_word_arbiter: LANES must be 1, 2 or 4");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rr_ptr;
  logic             owner;
  byte_t            op_b  [4];
  byte_t            res_b [4];
  logic [1:0]       grant;
  logic             accept;
  logic             deliver;
  word_t            sel_word;

  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];
  logic [1:0]       lane_sel [LANES];

  sub_word_rr_grant u_grant (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // Lane l handles byte cnt*LANES+l of the operand in the current SUB step.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sel[l] = 2'(int'(cnt) * LANES + l);
    assign lane_in[l]  = op_b[lane_sel[l]];

    sbox u_sbox (
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  // ready is held low while reset is asserted, even though state already reads IDLE.
  always_comb begin
    req_ready = (state == IDLE && rst) ? grant : 2'b00;
    accept    = |req_ready;
    deliver   = (state == RESP) && rsp_ready[owner];
    sel_word  = grant[1] ? req_word1 : req_word0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SUB;
      SUB:     if (cnt == LAST_CNT) state_nxt = RESP;
      RESP:    if (deliver) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = 2'b00;
    rsp_word  = '0;
    if (state == RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
      rsp_word  = {res_b[0], res_b[1], res_b[2], res_b[3]};
    end
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        op_b[k]  <= '0;
        res_b[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= grant[1];
            rr_ptr <= ~grant[1];
            cnt    <= '0;
            for (int k = 0; k < 4; k++) begin
              op_b[k] <= sel_word[31-8*k -: 8];
            end
          end
        end
        SUB: begin
          for (int l = 0; l < LANES; l++) begin
            res_b[lane_sel[l]] <= lane_out[l];
          end
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_word_arbiter.sv
// Directed bench for sub_word_arbiter: known S-box vectors, fairness,
// back-pressure hold and mid-substitution reset.
module tb_sub_word_arbiter;

  parameter int LANES = 1;
  localparam int LAT = 4 / LANES;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_word0;
  logic [31:0] req_word1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_word;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sub_word_arbiter #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_word0 (req_word0),
    .req_word1 (req_word1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_word  (rsp_word),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, count latency, optionally stall the response, then drain it.
  task automatic run_word(input int idx, input logic [31:0] word, input logic [31:0] exp,
                          input int hold);
    logic [1:0] own;
    own = (idx == 0) ? 2'b01 : 2'b10;
    if (idx == 0) req_word0 = word;
    else          req_word1 = word;
    req_valid = own;
    rsp_ready = 2'b00;
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(own));
    step();
    req_valid = 2'b00;
    for (int c = 1; c < LAT; c++) begin
      #1;
      check("rsp_valid_early", 32'(rsp_valid), 32'd0);
      check("busy_in_sub", 32'(busy), 32'd1);
      step();
    end
    step();
    #1;
    check("rsp_valid_owner", 32'(rsp_valid), 32'(own));
    check("rsp_word", rsp_word, exp);
    for (int h = 0; h < hold; h++) begin
      req_valid = ~own;
      rsp_ready = ~own;
      step();
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'(own));
      check("hold_rsp_word", rsp_word, exp);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 2'b00;
    rsp_ready = own;
    step();
    rsp_ready = 2'b00;
    #1;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rsp_word", rsp_word, 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nacc;
    int         last_cyc;
    logic [1:0] exp_grant;
    int         k;

    rst       = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_word0 = 32'h0;
    req_word1 = 32'h0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_word", rsp_word, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    rst       = 1'b1;
    req_valid = 2'b00;
    step();

    run_word(0, 32'h000153ff, 32'h637ced16, 0);
    run_word(0, 32'h53535353, 32'hedededed, 0);
    run_word(1, 32'hcf4f3c09, 32'h8a84eb01, 10);

    // Both requesters held valid: grants alternate, spaced LAT+2 cycles.
    req_word0 = 32'h000153ff;
    req_word1 = 32'hcf4f3c09;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    nacc      = 0;
    last_cyc  = 0;
    exp_grant = 2'b01;
    for (int cyc = 0; cyc < 80 && nacc < 6; cyc++) begin
      #1;
      if (rsp_valid != 2'b00) begin
        check("fair_rsp_word", rsp_word, rsp_valid[1] ? 32'h8a84eb01 : 32'h637ced16);
      end
      if (req_ready != 2'b00) begin
        check("fair_grant", 32'(req_ready), 32'(exp_grant));
        if (nacc > 0) check("fair_spacing", 32'(cyc - last_cyc), 32'(LAT + 2));
        exp_grant = ~exp_grant;
        last_cyc  = cyc;
        nacc++;
      end
      step();
    end
    check("fair_accepts", 32'(nacc), 32'd6);
    req_valid = 2'b00;
    repeat (LAT + 3) step();
    rsp_ready = 2'b00;
    #1;
    check("fair_drained", 32'(busy), 32'd0);

    // Reset in the middle of substitution drops the word.
    req_word0 = 32'h000153ff;
    req_valid = 2'b01;
    #1;
    check("mid_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b11;
    k = (LAT > 2) ? 2 : LAT - 1;
    repeat (k) step();
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_word", rsp_word, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step();
    rst       = 1'b1;
    req_valid = 2'b00;
    repeat (LAT + 2) step();
    #1;
    check("dropped_no_rsp", 32'(rsp_valid), 32'd0);
    check("dropped_idle", 32'(busy), 32'd0);
    req_valid = 2'b11;
    #1;
    check("prio_after_rst", 32'(req_ready), 32'd1);
    run_word(0, 32'h000153ff, 32'h637ced16, 0);
    run_word(1, 32'h00000000, 32'h63636363, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
